// File: rtl/ram_byte_bridge.sv
// ram_byte_bridge: bus-to-word-RAM front end with byte-enable writes via read-modify-write
module ram_byte_bridge #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DEPTH-1:0]   a,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH/8-1:0] be,
    input  logic               we,
    input  logic               rd,
    output logic [WIDTH-1:0]   spo,
    output logic               ready,
    output logic               err,
    output logic [DEPTH-1:0]   ram_a,
    output logic [WIDTH-1:0]   ram_d,
    output logic               ram_we,
    output logic               ram_rd,
    input  logic [WIDTH-1:0]   ram_spo
);
    localparam int NB = WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, RMW_RD, RMW_WR} state_t;

    state_t            state, next;
    logic [DEPTH-1:0]  addr;
    logic [WIDTH-1:0]  data;
    logic [NB-1:0]     bem;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = we ? ((&be || ~|be) ? WR : RMW_RD) : rd ? RD : IDLE;
            RD:      next = RD_CAP;
            RMW_RD:  next = RMW_WR;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr <= '0;
            data <= '0;
            bem  <= '0;
            spo  <= '0;
            err  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                addr <= a;
                data <= d;
                bem  <= be;
                if (rd && we) err <= 1'b1;
            end
            if (state == RD_CAP) spo <= ram_spo;
        end

    // Merged word is only strobed in RMW_WR, or in WR where bem is all-ones and it equals data
    always_comb begin
        ram_d = '0;
        for (int i = 0; i < NB; i++)
            ram_d[8*i +: 8] = bem[i] ? data[8*i +: 8] : ram_spo[8*i +: 8];
    end

    assign ready  = (state == IDLE) && !rd && !we;
    assign ram_a  = addr;
    assign ram_we = (state == RMW_WR) || (state == WR && |bem);
    assign ram_rd = (state == RD) || (state == RMW_RD);
endmodule

// File: tb/tb_ram_byte_bridge.sv
// tb_ram_byte_bridge: randomized self-checking bench against a byte-level memory model
module tb_ram_byte_bridge;
    logic        clk = 0, rst = 0;
    logic [9:0]  a = '0;
    logic [31:0] d = '0;
    logic [3:0]  be = '0;
    logic        we = 0, rd = 0;
    logic [31:0] spo, ram_d, ram_spo;
    logic        ready, err, ram_we, ram_rd;
    logic [9:0]  ram_a;

    int checks = 0, errors = 0;
    int we_cnt = 0, rd_cnt = 0;
    logic [31:0] last_wd;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    ram_byte_bridge dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .be(be), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .err(err), .ram_a(ram_a), .ram_d(ram_d),
        .ram_we(ram_we), .ram_rd(ram_rd), .ram_spo(ram_spo)
    );

    always #5 clk = ~clk;

    // Word RAM with a registered read port
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a] <= ram_d;
            last_wd    <= ram_d;
            we_cnt     <= we_cnt + 1;
        end
        if (ram_rd) rd_cnt <= rd_cnt + 1;
        ram_spo <= mem[ram_a];
    end

    function automatic void ref_write(input logic [9:0] aa, input logic [31:0] dd, input logic [3:0] bb);
        for (int i = 0; i < 4; i++)
            if (bb[i]) ref_mem[aa][8*i +: 8] = dd[8*i +: 8];
    endfunction

    // Drives one request pulse from a negedge and returns at the negedge where ready is back
    task automatic issue(input logic w, input logic r, input logic [9:0] aa, input logic [31:0] dd,
                         input logic [3:0] bb, output logic drop, output int busy,
                         output int nwe, output int nrd);
        int w0 = we_cnt;
        int r0 = rd_cnt;
        a = aa; d = dd; be = bb; we = w; rd = r;
        #1 drop = !ready;
        @(posedge clk);
        #1 we = 0; rd = 0;
        busy = 0;
        @(negedge clk);
        while (!ready && busy < 10) begin
            busy++;
            @(negedge clk);
        end
        nwe = we_cnt - w0;
        nrd = rd_cnt - r0;
    endtask

    logic drop;
    int busy, nwe, nrd;

    task automatic test_reset;
        rst = 1;
        #1;
        checks++; if (ram_we !== 0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        @(negedge clk); @(negedge clk);
        rst = 0;
        #1;
        checks++; if (spo !== 0 || err !== 0) begin errors++; $display("FAIL reset_out spo=%h err=%b want 0/0", spo, err); end
        checks++; if (ready !== 1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        @(negedge clk);
    endtask

    task automatic test_full_write;
        issue(1, 0, 5, 32'hDEADBEEF, 4'hF, drop, busy, nwe, nrd);
        ref_write(5, 32'hDEADBEEF, 4'hF);
        checks++; if (drop !== 1) begin errors++; $display("FAIL wr_ready_drop got %b want 1", drop); end
        checks++; if (busy != 1 || nwe != 1 || nrd != 0) begin errors++; $display("FAIL wr_timing busy=%0d we=%0d rd=%0d want 1/1/0", busy, nwe, nrd); end
        issue(0, 1, 5, 0, 0, drop, busy, nwe, nrd);
        checks++; if (busy != 2 || nwe != 0 || nrd != 1) begin errors++; $display("FAIL rd_timing busy=%0d we=%0d rd=%0d want 2/0/1", busy, nwe, nrd); end
        checks++; if (spo !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", spo); end
    endtask

    task automatic test_partial_write;
        issue(1, 0, 5, 32'h0000AA00, 4'b0010, drop, busy, nwe, nrd);
        ref_write(5, 32'h0000AA00, 4'b0010);
        checks++; if (busy != 2 || nwe != 1 || nrd != 1) begin errors++; $display("FAIL rmw_timing busy=%0d we=%0d rd=%0d want 2/1/1", busy, nwe, nrd); end
        checks++; if (last_wd !== 32'hDEADAAEF) begin errors++; $display("FAIL rmw_ram_d got %h want deadaaef", last_wd); end
        issue(0, 1, 5, 0, 0, drop, busy, nwe, nrd);
        checks++; if (spo !== 32'hDEADAAEF) begin errors++; $display("FAIL rmw_readback got %h want deadaaef", spo); end
    endtask

    task automatic test_zero_be;
        issue(1, 0, 5, 32'hFFFFFFFF, 4'h0, drop, busy, nwe, nrd);
        checks++; if (busy != 1 || nwe != 0 || nrd != 0) begin errors++; $display("FAIL zero_be busy=%0d we=%0d rd=%0d want 1/0/0", busy, nwe, nrd); end
        issue(0, 1, 5, 0, 0, drop, busy, nwe, nrd);
        checks++; if (spo !== ref_mem[5]) begin errors++; $display("FAIL zero_be_readback got %h want %h", spo, ref_mem[5]); end
    endtask

    task automatic test_conflict;
        logic [31:0] prev = spo;
        issue(1, 1, 7, 32'h12345678, 4'hF, drop, busy, nwe, nrd);
        ref_write(7, 32'h12345678, 4'hF);
        checks++; if (busy != 1 || nwe != 1 || nrd != 0) begin errors++; $display("FAIL conflict_timing busy=%0d we=%0d rd=%0d want 1/1/0", busy, nwe, nrd); end
        checks++; if (spo !== prev || err !== 1) begin errors++; $display("FAIL conflict spo=%h err=%b want %h/1", spo, err, prev); end
        issue(0, 1, 7, 0, 0, drop, busy, nwe, nrd);
        checks++; if (spo !== 32'h12345678 || err !== 1) begin errors++; $display("FAIL conflict_after spo=%h err=%b want 12345678/1", spo, err); end
    endtask

    task automatic test_reset_abort;
        int w0 = we_cnt;
        a = 5; d = 32'h77000000; be = 4'b1000; we = 1;
        @(posedge clk);
        #1 we = 0;
        #1 rst = 1;
        #1;
        checks++; if (ram_we !== 0 || spo !== 0 || err !== 0) begin errors++; $display("FAIL abort_reset we=%b spo=%h err=%b want 0/0/0", ram_we, spo, err); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (ready !== 1 || we_cnt != w0) begin errors++; $display("FAIL abort_release ready=%b strobes=%0d want 1/0", ready, we_cnt - w0); end
        @(negedge clk);
        issue(0, 1, 5, 0, 0, drop, busy, nwe, nrd);
        checks++; if (spo !== 32'hDEADAAEF) begin errors++; $display("FAIL abort_readback got %h want deadaaef", spo); end
    endtask

    task automatic test_back_to_back;
        int w0 = we_cnt;
        int r0 = rd_cnt;
        issue(1, 0, 10'h3FF, 32'hA5A5A5A5, 4'hF, drop, busy, nwe, nrd);
        ref_write(10'h3FF, 32'hA5A5A5A5, 4'hF);
        issue(0, 1, 10'h3FF, 0, 0, drop, busy, nwe, nrd);
        checks++; if (spo !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_data got %h want a5a5a5a5", spo); end
        checks++; if (we_cnt - w0 != 1 || rd_cnt - r0 != 1) begin errors++; $display("FAIL b2b_strobes we=%0d rd=%0d want 1/1", we_cnt - w0, rd_cnt - r0); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            logic [9:0]  aa = 10'($urandom_range(0, 7));
            logic [31:0] dd = $urandom;
            logic [3:0]  bb = 4'($urandom);
            logic        w  = $urandom_range(0, 1) == 1;
            int eb, ew, er;
            issue(w, !w, aa, dd, bb, drop, busy, nwe, nrd);
            if (w) begin
                ref_write(aa, dd, bb);
                eb = (bb == 4'hF || bb == 4'h0) ? 1 : 2;
                ew = bb != 0 ? 1 : 0;
                er = eb - 1;
            end else begin
                eb = 2; ew = 0; er = 1;
                checks++; if (spo !== ref_mem[aa]) begin errors++; $display("FAIL rand_read a=%0d got %h want %h", aa, spo, ref_mem[aa]); end
            end
            checks++; if (busy != eb || nwe != ew || nrd != er) begin errors++; $display("FAIL rand_timing w=%b be=%h busy=%0d we=%0d rd=%0d want %0d/%0d/%0d", w, bb, busy, nwe, nrd, eb, ew, er); end
        end
        for (int k = 0; k < 8; k++) begin
            issue(0, 1, 10'(k), 0, 0, drop, busy, nwe, nrd);
            checks++; if (spo !== ref_mem[k]) begin errors++; $display("FAIL rand_sweep a=%0d got %h want %h", k, spo, ref_mem[k]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        @(negedge clk);
        test_reset;
        test_full_write;
        test_partial_write;
        test_zero_be;
        test_conflict;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_byte_bridge.md
Name: ram_byte_bridge

Overview:
Bus-side front end placed directly upstream of the single-port word RAM (`simple_ram`). It accepts CPU/bus reads and byte-enabled writes and sequences them onto the RAM's word-only interface. The RAM has a 1-cycle registered read port (`spo`) and full-word writes only. Partial writes therefore run as read-modify-write. Bus-side handshake is rd/we pulse plus ready, matching the rest of the SoC bus.

Parameters:
WIDTH, 32, data word width; must be a multiple of 8; byte-enable width is WIDTH/8
DEPTH, 10, word-address width; RAM holds 2**DEPTH words

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
a  input  DEPTH  bus word address
d  input  WIDTH  bus write data
be  input  WIDTH/8  byte enables for writes; bit i covers d[8i+7:8i]; ignored for reads
we  input  1  write request pulse, sampled only in IDLE
rd  input  1  read request pulse, sampled only in IDLE
spo  output  WIDTH  read data, registered; valid once ready returns high after a read
ready  output  1  high when a new request may be issued
err  output  1  sticky: set when rd and we are sampled together in IDLE; cleared only by rst
ram_a  output  DEPTH  RAM address
ram_d  output  WIDTH  RAM write data
ram_we  output  1  RAM write strobe
ram_rd  output  1  RAM read indication
ram_spo  input  WIDTH  RAM registered read data (valid one cycle after ram_a is presented)

Behaviour:
- Reset (async, immediate): state=IDLE; spo=0; err=0; latched addr/data/be=0.
  - ram_we, ram_rd, ram_a and ram_d are decoded from state and latches, so ram_we=0 immediately.
  - Reset in any state aborts the operation; RAM contents must be unchanged by an aborted RMW.
- ready = (state==IDLE) & ~rd & ~we, combinational. It drops in the same cycle a request is presented.
- States: IDLE, WR, RD, RD_CAP, RMW_RD, RMW_WR.
- At the IDLE edge, latch a/d/be, then:
  - we=1: if be all-ones → WR; if be==0 → WR with no write; otherwise → RMW_RD.
  - rd=1 and we=0 → RD.
  - rd=1 and we=1: we wins, the read is dropped, spo is unchanged, err<=1.
  - Neither: stay in IDLE.
- WR (1 busy cycle): ram_a=latched addr, ram_d=latched data, ram_we=1 (0 when be==0). Next state IDLE.
- RD: ram_a=addr, ram_rd=1, ram_we=0. Next state RD_CAP.
- RD_CAP: spo<=ram_spo at the exit edge. Next state IDLE. Read busy time is 2 cycles.
- RMW_RD: ram_a=addr, ram_rd=1. Next state RMW_WR.
- RMW_WR: ram_a=addr, ram_we=1 for exactly this cycle. Next state IDLE. Partial-write busy time is 2 cycles.
  - ram_d byte i = be[i] ? latched d byte i : ram_spo byte i.
- Outside the cases above: ram_we=0 and ram_rd=0. ram_a holds the latched addr in all states.
- Requests outside IDLE are ignored. The master pulses rd/we for one cycle and waits for ready. A request held high re-triggers on return to IDLE; this is legal and produces a repeat transaction.
- spo changes only at the RD_CAP exit edge.
- Addressing is straight word indexing; address 2**DEPTH-1 needs no special handling and there is no wrap logic.

Test Plan:
1. Reset, then write a=5, d=32'hDEADBEEF, be=4'hF → ram_we high for exactly 1 cycle, ready low for 1 cycle. Then read a=5 → ready low for 2 cycles, then spo=32'hDEADBEEF.
2. After (1), write a=5, d=32'h0000AA00, be=4'b0010 → ram_rd then ram_we, one cycle each, with ram_d=32'hDEADAAEF. Read back gives 32'hDEADAAEF.
3. Write a=5, be=4'h0, d=32'hFFFFFFFF → ram_we never asserts, 1 busy cycle; read back is still 32'hDEADAAEF.
4. Assert rd=1 and we=1 together with a=7, d=32'h12345678, be=4'hF → a write is performed and spo is unchanged. err=1 and stays 1 through later transactions until rst.
5. Start a partial write (be=4'b1000) to a=5; assert rst during RMW_RD → ram_we never pulses, spo=0, err=0, ready=1 once rst releases. a=5 still reads 32'hDEADAAEF.
6. Back-to-back: write a=2**DEPTH-1 with 32'hA5A5A5A5, then issue a read in the first cycle ready is high → spo=32'hA5A5A5A5, with no lost or duplicated RAM strobes.
